// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package whack_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      PLAY = 3'd2,
      HIT  = 3'd3,
      OVER = 3'd4
   } state_t;

   localparam int NUM_MOLES = 3;
   localparam int SPEED_W   = 28;

   localparam logic [1:0] SEED_A = 2'b01;
   localparam logic [1:0] SEED_B = 2'b10;
   localparam logic [1:0] SEED_C = 2'b11;

   // 00 would lock the mole LFSR, so the rotation skips it.
   function automatic logic [1:0] next_seed(input logic [1:0] s);
      case (s)
         SEED_A:  return SEED_B;
         SEED_B:  return SEED_C;
         default: return SEED_A;
      endcase
   endfunction

endpackage

// File: rtl/whack_game_controller_tick_divider.sv
// Game-timer prescaler: down-counter that strobes once every TICK_CYCLES enabled cycles.
module tick_divider #(
   parameter int TICK_CYCLES = 50_000_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic strobe
);
   localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      strobe = 1'b0;
      if (clr) begin
         cnt_d = RELOAD;
      end else if (en) begin
         if (cnt_q == '0) begin
            strobe = 1'b1;
            cnt_d  = RELOAD;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt_q <= RELOAD;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/whack_game_controller.sv
// Game sequencer: start/score/miss/timer/difficulty control for the mole display controller.
// state | meaning
// IDLE  | waiting for start edge, seed rotating
// LOAD  | one cycle, reload game counters
// PLAY  | game running, buttons scored
// HIT   | one cycle turnoff strobe after a hit
// OVER  | game finished, results held, seed rotating
module whack_game_controller
   import whack_pkg::*;
#(
   parameter int                 TICK_CYCLES    = 50_000_000,
   parameter int                 GAME_SECONDS   = 30,
   parameter logic [SPEED_W-1:0] SPEED_INIT     = 28'd50_000_000,
   parameter logic [SPEED_W-1:0] SPEED_STEP     = 28'd5_000_000,
   parameter logic [SPEED_W-1:0] SPEED_MIN      = 28'd10_000_000,
   parameter int                 HITS_PER_LEVEL = 4,
   parameter int                 MAX_MISSES     = 3
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [NUM_MOLES-1:0] hit_btn,
   input  logic [NUM_MOLES-1:0] mole,
   output logic                 game,
   output logic                 turnoff,
   output logic [1:0]           seed,
   output logic [SPEED_W-1:0]   speed,
   output logic [7:0]           score,
   output logic [7:0]           time_left,
   output logic [3:0]           misses,
   output logic [3:0]           level,
   output logic                 game_over
);
   localparam int HL_W = $clog2(HITS_PER_LEVEL + 1);

   state_t               state_q, state_d;
   logic                 game_q, game_d, turnoff_q, turnoff_d, game_over_q, game_over_d;
   logic [1:0]           seed_q, seed_d;
   logic [SPEED_W-1:0]   speed_q, speed_d;
   logic [7:0]           score_q, score_d, time_left_q, time_left_d;
   logic [3:0]           misses_q, misses_d, level_q, level_d;
   logic [HL_W-1:0]      hits_lvl_q, hits_lvl_d;
   logic                 start_q;
   logic [NUM_MOLES-1:0] btn_q;
   logic                 start_edge, is_hit, tick;
   logic [NUM_MOLES-1:0] btn_edge;

   tick_divider #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clock  (clock),
      .reset_n(reset_n),
      .en     ((state_q == PLAY) || (state_q == HIT)),
      .clr    (state_q == LOAD),
      .strobe (tick)
   );

   always_comb begin
      start_edge  = start & ~start_q;
      btn_edge    = hit_btn & ~btn_q;
      is_hit      = $onehot(btn_edge) && ((btn_edge & mole) != '0);
      state_d     = state_q;
      seed_d      = seed_q;
      speed_d     = speed_q;
      score_d     = score_q;
      time_left_d = time_left_q;
      misses_d    = misses_q;
      level_d     = level_q;
      hits_lvl_d  = hits_lvl_q;
      case (state_q)
         IDLE, OVER: begin
            seed_d = next_seed(seed_q);
            if (start_edge) state_d = LOAD;
         end
         LOAD: begin
            score_d     = '0;
            misses_d    = '0;
            level_d     = '0;
            hits_lvl_d  = '0;
            speed_d     = SPEED_INIT;
            time_left_d = 8'(GAME_SECONDS);
            state_d     = PLAY;
         end
         PLAY: begin
            if (is_hit) begin
               state_d = HIT;
               if (score_q != 8'hFF) score_d = score_q + 8'd1;
               if (hits_lvl_q == HL_W'(HITS_PER_LEVEL - 1)) begin
                  hits_lvl_d = '0;
                  if (level_q != 4'hF) level_d = level_q + 4'd1;
                  // speed never drops below SPEED_MIN, so the difference cannot underflow
                  speed_d = ((speed_q - SPEED_MIN) >= SPEED_STEP) ? speed_q - SPEED_STEP : SPEED_MIN;
               end else begin
                  hits_lvl_d = hits_lvl_q + HL_W'(1);
               end
            end else if (btn_edge != '0) begin
               misses_d = misses_q + 4'd1;
               if (misses_d == 4'(MAX_MISSES)) state_d = OVER;
            end
         end
         HIT:     state_d = PLAY;
         default: state_d = IDLE;
      endcase
      // expiry overrides HIT so a last-second hit scores without a turnoff pulse
      if (tick) begin
         time_left_d = time_left_q - 8'd1;
         if (time_left_d == '0) state_d = OVER;
      end
      game_d      = (state_d == PLAY) || (state_d == HIT);
      turnoff_d   = (state_d == HIT);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         game_q      <= 1'b0;
         turnoff_q   <= 1'b0;
         game_over_q <= 1'b0;
         seed_q      <= SEED_A;
         speed_q     <= SPEED_INIT;
         score_q     <= '0;
         time_left_q <= 8'(GAME_SECONDS);
         misses_q    <= '0;
         level_q     <= '0;
         hits_lvl_q  <= '0;
         start_q     <= 1'b0;
         btn_q       <= '0;
      end else begin
         state_q     <= state_d;
         game_q      <= game_d;
         turnoff_q   <= turnoff_d;
         game_over_q <= game_over_d;
         seed_q      <= seed_d;
         speed_q     <= speed_d;
         score_q     <= score_d;
         time_left_q <= time_left_d;
         misses_q    <= misses_d;
         level_q     <= level_d;
         hits_lvl_q  <= hits_lvl_d;
         start_q     <= start;
         btn_q       <= hit_btn;
      end
   end

   assign game      = game_q;
   assign turnoff   = turnoff_q;
   assign game_over = game_over_q;
   assign seed      = seed_q;
   assign speed     = speed_q;
   assign score     = score_q;
   assign time_left = time_left_q;
   assign misses    = misses_q;
   assign level     = level_q;

endmodule
